// File: rtl/full_adder_pkg.sv
// Shared arithmetic definitions for the registered ripple-carry adder.
// Holds width limits, the flag bundle type and the flag derivation helper.
package arith_pkg;

  localparam int FA_WIDTH_DEFAULT = 1;
  localparam int FA_WIDTH_MAX     = 64;

  typedef struct packed {
    logic c;
    logic ovf;
  } fa_flags_t;

  // Signed overflow is the disagreement between the carry entering and leaving the MSB.
  function automatic fa_flags_t fa_flags(input logic carry_into_msb,
                                         input logic carry_out_msb);
    fa_flags_t flags;
    flags.c   = carry_out_msb;
    flags.ovf = carry_into_msb ^ carry_out_msb;
    return flags;
  endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder; master drives operands, slave returns results.
interface full_adder_if
  import arith_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             ovf;
  logic             out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  s, c, ovf, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output s, c, ovf, out_valid
  );

endinterface

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full-adder cell, the link of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {c, s} = a + b + cin one cycle after in_valid.
// Outputs come straight from flops; results hold while in_valid is low.
module full_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  full_adder_if.slave bus
);

  if (WIDTH < 1 || WIDTH > FA_WIDTH_MAX) begin : g_width_check
    $fatal(1, "full_adder: WIDTH %0d outside 1..%0d", WIDTH, FA_WIDTH_MAX);
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;
  fa_flags_t        flags_comb;

  assign carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .cin  (carry[i]),
      .s    (sum_comb[i]),
      .cout (carry[i+1])
    );
  end

  assign flags_comb = fa_flags(carry[WIDTH-1], carry[WIDTH]);

  logic [WIDTH-1:0] s_q, s_d;
  fa_flags_t        flags_q, flags_d;
  logic             valid_q, valid_d;

  // Idle cycles keep the last result so operand garbage never reaches the outputs.
  always_comb begin
    s_d     = s_q;
    flags_d = flags_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      s_d     = sum_comb;
      flags_d = flags_comb;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.c         = flags_q.c;
  assign bus.ovf       = flags_q.ovf;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 8, 16 and 64 against an arithmetic model.
module tb_full_adder;
  import arith_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1))  if_w1 ();
  full_adder_if #(.WIDTH(8))  if_w8 ();
  full_adder_if #(.WIDTH(16)) if_w16 ();
  full_adder_if #(.WIDTH(64)) if_w64 ();

  full_adder #(.WIDTH(1))  dut_w1  (.clk(clk), .rst(rst), .bus(if_w1));
  full_adder #(.WIDTH(8))  dut_w8  (.clk(clk), .rst(rst), .bus(if_w8));
  full_adder #(.WIDTH(16)) dut_w16 (.clk(clk), .rst(rst), .bus(if_w16));
  full_adder #(.WIDTH(64)) dut_w64 (.clk(clk), .rst(rst), .bus(if_w64));

  // Result packing used everywhere: {pad, out_valid, ovf, c, s zero-extended to 64}.
  function automatic logic [67:0] pack(input logic v, input logic ovf, input logic c,
                                       input logic [63:0] s);
    return {1'b0, v, ovf, c, s};
  endfunction

  // Reference: plain integer addition in wide arithmetic; overflow by the sign rule.
  function automatic logic [67:0] model(input int w, input logic [63:0] a,
                                        input logic [63:0] b, input logic cin);
    logic [63:0]  mask;
    logic [127:0] full;
    logic [63:0]  sum;
    logic         carry;
    logic         ovf;
    mask  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    full  = {64'd0, a & mask} + {64'd0, b & mask} + {127'd0, cin};
    sum   = full[63:0] & mask;
    carry = full[w];
    ovf   = (a[w-1] == b[w-1]) && (sum[w-1] != a[w-1]);
    return pack(1'b1, ovf, carry, sum);
  endfunction

  function automatic logic [67:0] observe(input int w);
    case (w)
      1:       return pack(if_w1.out_valid,  if_w1.ovf,  if_w1.c,  {63'd0, if_w1.s});
      8:       return pack(if_w8.out_valid,  if_w8.ovf,  if_w8.c,  {56'd0, if_w8.s});
      16:      return pack(if_w16.out_valid, if_w16.ovf, if_w16.c, {48'd0, if_w16.s});
      default: return pack(if_w64.out_valid, if_w64.ovf, if_w64.c, if_w64.s);
    endcase
  endfunction

  task automatic applyStimulus(input int w, input logic v, input logic [63:0] a,
                               input logic [63:0] b, input logic cin);
    case (w)
      1: begin
        if_w1.in_valid = v; if_w1.a = a[0]; if_w1.b = b[0]; if_w1.cin = cin;
      end
      8: begin
        if_w8.in_valid = v; if_w8.a = a[7:0]; if_w8.b = b[7:0]; if_w8.cin = cin;
      end
      16: begin
        if_w16.in_valid = v; if_w16.a = a[15:0]; if_w16.b = b[15:0]; if_w16.cin = cin;
      end
      default: begin
        if_w64.in_valid = v; if_w64.a = a; if_w64.b = b; if_w64.cin = cin;
      end
    endcase
  endtask

  task automatic checkOutput(input string tag, input int w, input logic [67:0] expected);
    logic [67:0] observed;
    observed = observe(w);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s w%0d: observed 0x%0h expected 0x%0h", tag, w, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]  cs_table [8];
    logic [67:0] last16, last64, exp16, exp64;
    logic [63:0] ra, rb;
    logic        rc, rv;

    cs_table = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    rst = 1'b1;
    applyStimulus(1, 1'b0, 64'd0, 64'd0, 1'b0);
    applyStimulus(8, 1'b0, 64'd0, 64'd0, 1'b0);
    applyStimulus(16, 1'b0, 64'd0, 64'd0, 1'b0);
    applyStimulus(64, 1'b0, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    tick();
    tick();
    checkOutput("reset", 1, pack(1'b0, 1'b0, 1'b0, 64'd0));
    checkOutput("reset", 8, pack(1'b0, 1'b0, 1'b0, 64'd0));
    checkOutput("reset", 16, pack(1'b0, 1'b0, 1'b0, 64'd0));
    checkOutput("reset", 64, pack(1'b0, 1'b0, 1'b0, 64'd0));
    rst = 1'b0;

    $display("[TB] WIDTH=1 truth table");
    for (int i = 0; i < 8; i++) begin
      logic [2:0] vec;
      vec = 3'(i);
      applyStimulus(1, 1'b1, {63'd0, vec[2]}, {63'd0, vec[1]}, vec[0]);
      tick();
      checkOutput($sformatf("truth%0d", i), 1,
                  pack(1'b1, vec[0] ^ cs_table[i][1], cs_table[i][1], {63'd0, cs_table[i][0]}));
    end
    applyStimulus(1, 1'b0, 64'd0, 64'd0, 1'b0);

    $display("[TB] WIDTH=8 directed vectors");
    applyStimulus(8, 1'b1, 64'hFF, 64'h00, 1'b1);
    tick();
    checkOutput("ff_00_1", 8, pack(1'b1, 1'b0, 1'b1, 64'h00));
    applyStimulus(8, 1'b1, 64'h7F, 64'h01, 1'b0);
    tick();
    checkOutput("7f_01_0", 8, pack(1'b1, 1'b1, 1'b0, 64'h80));
    applyStimulus(8, 1'b1, 64'h80, 64'h80, 1'b0);
    tick();
    checkOutput("80_80_0", 8, pack(1'b1, 1'b1, 1'b1, 64'h00));
    applyStimulus(8, 1'b1, 64'h12, 64'h34, 1'b1);
    tick();
    checkOutput("12_34_1", 8, pack(1'b1, 1'b0, 1'b0, 64'h47));

    $display("[TB] WIDTH=8 hold behaviour");
    applyStimulus(8, 1'b1, 64'h05, 64'h03, 1'b0);
    tick();
    checkOutput("hold_load", 8, pack(1'b1, 1'b0, 1'b0, 64'h08));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8, 1'b0, {32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom));
      tick();
      checkOutput($sformatf("hold%0d", i), 8, pack(1'b0, 1'b0, 1'b0, 64'h08));
    end

    $display("[TB] WIDTH=8 reset mid-stream");
    applyStimulus(8, 1'b1, 64'h55, 64'h22, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_prio", 8, pack(1'b0, 1'b0, 1'b0, 64'd0));
    applyStimulus(8, 1'b0, 64'h55, 64'h22, 1'b0);
    tick();
    checkOutput("rst_dropped", 8, pack(1'b0, 1'b0, 1'b0, 64'd0));
    applyStimulus(8, 1'b1, 64'h01, 64'h01, 1'b0);
    tick();
    checkOutput("post_rst", 8, pack(1'b1, 1'b0, 1'b0, 64'h02));
    applyStimulus(8, 1'b0, 64'd0, 64'd0, 1'b0);

    $display("[TB] WIDTH=16/64 random streams");
    last16 = pack(1'b0, 1'b0, 1'b0, 64'd0);
    last64 = pack(1'b0, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 1200; i++) begin
      rv = ($urandom_range(0, 9) != 0);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      if (i % 50 == 7) begin
        rv = 1'b1;
        ra = {64{1'b1}};
        rb = {64{1'b1}};
        rc = 1'b1;
      end
      applyStimulus(16, rv, ra, rb, rc);
      applyStimulus(64, rv, ~rb, ra, rc);
      if (rv) begin
        last16 = model(16, ra, rb, rc);
        last64 = model(64, ~rb, ra, rc);
        if (i % 50 == 7) last64 = model(64, ra, rb, rc);
      end
      if (i % 50 == 7) applyStimulus(64, rv, ra, rb, rc);
      exp16 = last16;
      exp64 = last64;
      exp16[66] = rv;
      exp64[66] = rv;
      tick();
      checkOutput($sformatf("rand16_%0d", i), 16, exp16);
      checkOutput($sformatf("rand64_%0d", i), 64, exp64);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
# full_adder

Registered, width-parameterized binary adder built as a ripple chain of 1-bit full-adder cells. Computes {c, s} = a + b + cin and presents the result one clock after a valid input, with carry-out and signed-overflow flags. It is the basic arithmetic leaf for datapath blocks. With WIDTH = 1 it is the classic 1-bit full adder: A, B, Cin in; S, C out.

## Interface
- WIDTH, default 1: operand width in bits; legal range 1..64.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  when high, operands are sampled on this clock edge.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- s  output  WIDTH  registered sum bits.
- c  output  1  registered carry-out of the MSB.
- ovf  output  1  registered signed overflow: carry into the MSB XOR carry out of the MSB.
- out_valid  output  1  high for exactly one cycle per accepted input.

## Operation
- Bit i cell: s_i = a_i ^ b_i ^ carry_i; carry_{i+1} = (a_i & b_i) | (carry_i & (a_i ^ b_i)); carry_0 = cin.
- Result is exact, WIDTH+1 bits: {c, s} = a + b + cin, modulo 2^(WIDTH+1); no saturation.
- ovf: for WIDTH = 1, ovf = cin ^ c.
- When in_valid = 1 at a clock edge:
  - s, c and ovf load the combinational result.
  - out_valid becomes 1.
- When in_valid = 0 at a clock edge:
  - s, c and ovf hold their previous values.
  - out_valid becomes 0.
- Back-to-back: a new result is accepted every cycle. No backpressure and no ready signal.
- X or Z on an operand while in_valid = 0 must not disturb the held outputs.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on s/c/ovf/out_valid after edge N.
- Throughput 1 result per cycle.
- Reset at a clock edge while rst = 1: s = 0, c = 0, ovf = 0, out_valid = 0.
- Reset has priority over in_valid when both are high on the same edge; that input is dropped.
- Reset mid-stream discards any in-flight result. The first valid input after rst falls produces out_valid one cycle later.
- Combinational path a/b/cin -> register is a WIDTH-deep ripple chain. No lookahead is required; the path must close timing at WIDTH = 64.
- Outputs come directly from flops, with no combinational path from input to output.

## Structure
- Shared package arith_pkg holds:
  - constant FA_WIDTH_DEFAULT = 1;
  - constant FA_WIDTH_MAX = 64;
  - typedef fa_flags_t = struct {c, ovf}.
- Sub-module full_adder_cell: purely combinational 1-bit cell (a, b, cin -> s, cout), instantiated WIDTH times via a generate loop.
- Top level holds:
  - the carry chain wiring;
  - ovf derivation;
  - the output register bank and out_valid flop.
- Elaboration-time check: WIDTH outside 1..64 is a fatal error.

## Test plan
- WIDTH = 1, exhaustive truth table, one vector per cycle with in_valid = 1, vectors {a,b,cin} = 000..111. Each result appears on the following cycle:
  - {c,s} = 00, 01, 01, 10, 01, 10, 10, 11.
  - ovf = cin ^ c.
- WIDTH = 8, 0xFF + 0x00 + cin = 1 -> s = 0x00, c = 1, ovf = 0. Then 0x7F + 0x01 + 0 -> s = 0x80, c = 0, ovf = 1.
- WIDTH = 8, 0x80 + 0x80 + 0 -> s = 0x00, c = 1, ovf = 1. Then 0x12 + 0x34 + 1 -> s = 0x47, c = 0, ovf = 0.
- Hold behaviour: valid 0x05 + 0x03, then in_valid = 0 for 3 cycles with random operands:
  - s stays 0x08 throughout;
  - out_valid pulses for exactly 1 cycle.
- Reset mid-stream: rst = 1 and in_valid = 1 on the same edge -> all outputs 0 the next cycle, and the input is dropped. Release rst, apply 0x01 + 0x01 -> s = 0x02, out_valid = 1 after one cycle.
- Random WIDTH = 16 and WIDTH = 64 vectors (≥1000 each) compared against a behavioural a + b + cin model, including all-ones operands with cin = 1.
